// File: rtl/hazard_forward_sb_if.sv
// ID-stage hazard/forwarding bus: decode read ports, pipeline stage write-backs, long-latency unit events.
// Optional perf counter outputs appear when HAZARD_PERF_EN is defined.
interface hazard_forward_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRP  = 2
);
  logic [NRP*5-1:0]    id_rR;
  logic [NRP-1:0]      id_re;
  logic [NRP*XLEN-1:0] id_rD;
  logic [4:0]          id_wR;
  logic                id_we;

  logic [4:0]          ex_wR;
  logic [4:0]          mem_wR;
  logic [4:0]          wb_wR;
  logic                ex_we;
  logic                mem_we;
  logic                wb_we;
  logic                ex_rdy;
  logic                mem_rdy;
  logic [XLEN-1:0]     ex_wD;
  logic [XLEN-1:0]     mem_wD;
  logic [XLEN-1:0]     wb_wD;

  logic                lu_issue;
  logic [4:0]          lu_wR;
  logic                lu_done;
  logic [4:0]          lu_done_wR;
  logic [XLEN-1:0]     lu_done_wD;

  logic [NRP*XLEN-1:0] new_rD;
  logic                stall;
  logic [31:0]         busy_vec;
  logic                hazard_err;
`ifdef HAZARD_PERF_EN
  logic [31:0]         perf_stall_cnt;
  logic [31:0]         perf_fwd_cnt;
`endif

  modport master (
    output id_rR, id_re, id_rD, id_wR, id_we,
    output ex_wR, mem_wR, wb_wR, ex_we, mem_we, wb_we, ex_rdy, mem_rdy,
    output ex_wD, mem_wD, wb_wD,
    output lu_issue, lu_wR, lu_done, lu_done_wR, lu_done_wD,
    input  new_rD, stall, busy_vec, hazard_err
`ifdef HAZARD_PERF_EN
    , input perf_stall_cnt, perf_fwd_cnt
`endif
  );

  modport slave (
    input  id_rR, id_re, id_rD, id_wR, id_we,
    input  ex_wR, mem_wR, wb_wR, ex_we, mem_we, wb_we, ex_rdy, mem_rdy,
    input  ex_wD, mem_wD, wb_wD,
    input  lu_issue, lu_wR, lu_done, lu_done_wR, lu_done_wD,
    output new_rD, stall, busy_vec, hazard_err
`ifdef HAZARD_PERF_EN
    , output perf_stall_cnt, perf_fwd_cnt
`endif
  );
endinterface

// File: rtl/hazard_forward_sb.sv
// ID-stage forwarding unit with long-latency scoreboard, RAW/WAW stall and sticky stall watchdog.
// Define HAZARD_PERF_EN to add saturating stall/forward performance counters.
module hazard_forward_sb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NRP       = 2,
  parameter int unsigned STALL_MAX = 64
) (
  input logic                clk,
  input logic                rst,
  hazard_forward_sb_if.slave bus
);
  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);

  logic [31:0]               busy_q;
  logic [31:0]               busy_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_d;
  logic                      err_q;
  logic                      err_d;
  logic [NRP-1:0]            raw_c;
  logic [NRP-1:0][XLEN-1:0]  new_rd_c;
  logic                      waw_c;
  logic                      stall_c;
`ifdef HAZARD_PERF_EN
  logic [NRP-1:0]            fwd_c;
`endif

  // Per read port: stage match, priority forwarding mux and RAW stall source.
  for (genvar k = 0; k < NRP; k++) begin : g_port
    logic [RW-1:0] rr;
    logic          nz;
    logic          ex_m;
    logic          mem_m;
    logic          wb_m;
    logic          lu_m;

    assign rr    = bus.id_rR[k*RW +: RW];
    assign nz    = (rr != '0);
    assign ex_m  = bus.id_re[k] & bus.ex_we  & (rr == bus.ex_wR)  & nz;
    assign mem_m = bus.id_re[k] & bus.mem_we & (rr == bus.mem_wR) & nz;
    assign wb_m  = bus.id_re[k] & bus.wb_we  & (rr == bus.wb_wR)  & nz;
    assign lu_m  = bus.lu_done & (bus.lu_done_wR == rr) & nz;

    // A completing long-latency result satisfies the busy register this very cycle.
    assign raw_c[k] = (ex_m & ~bus.ex_rdy) | (mem_m & ~bus.mem_rdy)
                    | (bus.id_re[k] & busy_q[rr] & ~lu_m);

    assign new_rd_c[k] = ex_m  ? bus.ex_wD  :
                         mem_m ? bus.mem_wD :
                         wb_m  ? bus.wb_wD  :
                         lu_m  ? bus.lu_done_wD :
                                 bus.id_rD[k*XLEN +: XLEN];
`ifdef HAZARD_PERF_EN
    assign fwd_c[k] = ex_m | mem_m | wb_m | (bus.id_re[k] & lu_m);
`endif
  end

  assign waw_c = bus.id_we & (bus.id_wR != '0) & busy_q[bus.id_wR]
               & ~(bus.lu_done & (bus.lu_done_wR == bus.id_wR));

  assign stall_c      = (|raw_c) | waw_c;
  assign bus.stall    = stall_c;
  assign bus.new_rD   = new_rd_c;
  assign bus.busy_vec = busy_q;
  assign bus.hazard_err = err_q;

  // Scoreboard (set beats clear, x0 never busy) and saturating stall watchdog.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    err_d  = err_q;
    if (bus.lu_done) begin
      busy_d[bus.lu_done_wR] = 1'b0;
    end
    if (bus.lu_issue && (bus.lu_wR != '0)) begin
      busy_d[bus.lu_wR] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (stall_c) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    if (cnt_d == CNT_MAX) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_stall_d;
  logic [31:0] perf_fwd_q;
  logic [31:0] perf_fwd_d;

  // Saturating event counters; forwards only count on cycles that advance.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_fwd_d   = perf_fwd_q;
    if (stall_c && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (!stall_c && (|fwd_c) && (perf_fwd_q != '1)) begin
      perf_fwd_d = perf_fwd_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_fwd_cnt   = perf_fwd_q;
`endif
endmodule

// File: tb/tb_hazard_forward_sb.sv
// Bench for hazard_forward_sb: directed vectors with literal checks plus a rule-level model checked every cycle.
module tb_hazard_forward_sb;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned NRP       = 2;
  localparam int unsigned STALL_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_sb_if #(.XLEN(XLEN), .NRP(NRP)) bus ();

  hazard_forward_sb #(.XLEN(XLEN), .NRP(NRP), .STALL_MAX(STALL_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: register sets, stall counter, sticky error ----------------
  bit mvalid = 1'b0;
  bit mbusy[32];
  int mcnt;
  bit merr;
  longint mps;
  longint mpf;

  function automatic logic [4:0] rr_of(input int k);
    return bus.id_rR[k*5 +: 5];
  endfunction

  function automatic bit reads(input int k, input logic we, input logic [4:0] wr);
    return bus.id_re[k] && we && (rr_of(k) == wr) && (rr_of(k) != 5'd0);
  endfunction

  function automatic bit lu_hits(input logic [4:0] r);
    return bus.lu_done && (bus.lu_done_wR == r) && (r != 5'd0);
  endfunction

  function automatic bit m_stall();
    bit s = 1'b0;
    for (int k = 0; k < NRP; k++) begin
      if (reads(k, bus.ex_we, bus.ex_wR) && !bus.ex_rdy) s = 1'b1;
      if (reads(k, bus.mem_we, bus.mem_wR) && !bus.mem_rdy) s = 1'b1;
      if (bus.id_re[k] && mbusy[rr_of(k)] && !lu_hits(rr_of(k))) s = 1'b1;
    end
    if (bus.id_we && bus.id_wR != 5'd0 && mbusy[bus.id_wR] && !lu_hits(bus.id_wR)) s = 1'b1;
    return s;
  endfunction

  function automatic bit m_any_fwd();
    bit f = 1'b0;
    for (int k = 0; k < NRP; k++) begin
      if (reads(k, bus.ex_we, bus.ex_wR) || reads(k, bus.mem_we, bus.mem_wR) ||
          reads(k, bus.wb_we, bus.wb_wR) || (bus.id_re[k] && lu_hits(rr_of(k)))) f = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [XLEN-1:0] m_data(input int k, output bit dc);
    dc = 1'b0;
    if (reads(k, bus.ex_we, bus.ex_wR)) begin
      dc = !bus.ex_rdy;
      return bus.ex_wD;
    end
    if (reads(k, bus.mem_we, bus.mem_wR)) begin
      dc = !bus.mem_rdy;
      return bus.mem_wD;
    end
    if (reads(k, bus.wb_we, bus.wb_wR)) return bus.wb_wD;
    if (lu_hits(rr_of(k))) return bus.lu_done_wD;
    return bus.id_rD[k*XLEN +: XLEN];
  endfunction

  // Model state advances on the same edge as the DUT, from the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mcnt = 0; merr = 1'b0; mps = 0; mpf = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      bit s;
      s = m_stall();
      if (s && mps < 64'hFFFF_FFFF) mps++;
      if (!s && m_any_fwd() && mpf < 64'hFFFF_FFFF) mpf++;
      if (bus.lu_done) mbusy[bus.lu_done_wR] = 1'b0;
      if (bus.lu_issue && bus.lu_wR != 5'd0) mbusy[bus.lu_wR] = 1'b1;
      mcnt = s ? ((mcnt < int'(STALL_MAX)) ? mcnt + 1 : mcnt) : 0;
      if (mcnt == int'(STALL_MAX)) merr = 1'b1;
    end
  end

  // Single compare process on the falling edge.
  always @(negedge clk) begin
    if (mvalid) begin
      logic [31:0] bv;
      logic [XLEN-1:0] d;
      bit dc;
      chk("m_stall", 32'(bus.stall), 32'(m_stall()));
      for (int k = 0; k < NRP; k++) begin
        d = m_data(k, dc);
        if (!dc) chk($sformatf("m_new_rD%0d", k), bus.new_rD[k*XLEN +: XLEN], d);
      end
      for (int i = 0; i < 32; i++) bv[i] = mbusy[i];
      chk("m_busy_vec", bus.busy_vec, bv);
      chk("m_hazard_err", 32'(bus.hazard_err), 32'(merr));
`ifdef HAZARD_PERF_EN
      chk("m_perf_stall", bus.perf_stall_cnt, 32'(mps));
      chk("m_perf_fwd", bus.perf_fwd_cnt, 32'(mpf));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    bus.id_rR = '0; bus.id_re = '0; bus.id_rD = '0; bus.id_wR = '0; bus.id_we = 1'b0;
    bus.ex_wR = '0; bus.mem_wR = '0; bus.wb_wR = '0;
    bus.ex_we = 1'b0; bus.mem_we = 1'b0; bus.wb_we = 1'b0;
    bus.ex_rdy = 1'b1; bus.mem_rdy = 1'b1;
    bus.ex_wD = '0; bus.mem_wD = '0; bus.wb_wD = '0;
    bus.lu_issue = 1'b0; bus.lu_wR = '0; bus.lu_done = 1'b0; bus.lu_done_wR = '0; bus.lu_done_wD = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [4:0] r, input logic [XLEN-1:0] d);
    bus.id_rR[k*5 +: 5]       = r;
    bus.id_rD[k*XLEN +: XLEN] = d;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy_vec, 32'h0);
    chk("rst_err", 32'(bus.hazard_err), 32'h0);
    tick();

    // EX beats MEM on the same register
    clr();
    bus.ex_we = 1'b1; bus.ex_wR = 5'd5; bus.ex_wD = 32'h11;
    bus.mem_we = 1'b1; bus.mem_wR = 5'd5; bus.mem_wD = 32'h22;
    set_rd(0, 5'd5, 32'hDEAD); bus.id_re = 2'b01;
    @(negedge clk);
    chk("ex_fwd", bus.new_rD[31:0], 32'h11);
    chk("ex_fwd_stall", 32'(bus.stall), 32'h0);
    tick();

    // load-use, then the value arrives from MEM
    clr();
    bus.ex_we = 1'b1; bus.ex_wR = 5'd7; bus.ex_rdy = 1'b0;
    set_rd(1, 5'd7, 32'hBEEF); bus.id_re = 2'b10;
    @(negedge clk);
    chk("load_use_stall", 32'(bus.stall), 32'h1);
    tick();
    clr();
    bus.mem_we = 1'b1; bus.mem_wR = 5'd7; bus.mem_wD = 32'hABCD;
    set_rd(1, 5'd7, 32'hBEEF); bus.id_re = 2'b10;
    @(negedge clk);
    chk("mem_fwd_stall", 32'(bus.stall), 32'h0);
    chk("mem_fwd", bus.new_rD[63:32], 32'hABCD);
    tick();

    // WB forward on one port, MEM on the other
    clr();
    bus.wb_we = 1'b1; bus.wb_wR = 5'd4; bus.wb_wD = 32'h44;
    bus.mem_we = 1'b1; bus.mem_wR = 5'd6; bus.mem_wD = 32'h66;
    set_rd(0, 5'd6, 32'h1); set_rd(1, 5'd4, 32'h2); bus.id_re = 2'b11;
    @(negedge clk);
    chk("wb_fwd", bus.new_rD[63:32], 32'h44);
    chk("mem_fwd_p0", bus.new_rD[31:0], 32'h66);
    tick();

    // scoreboard RAW
    clr();
    bus.lu_issue = 1'b1; bus.lu_wR = 5'd9;
    tick();
    clr();
    set_rd(0, 5'd9, 32'hCAFE); bus.id_re = 2'b01;
    @(negedge clk);
    chk("sb_busy9", bus.busy_vec, 32'h200);
    chk("sb_raw_stall", 32'(bus.stall), 32'h1);
    tick();
    clr();
    set_rd(0, 5'd9, 32'hCAFE); bus.id_re = 2'b01;
    bus.lu_done = 1'b1; bus.lu_done_wR = 5'd9; bus.lu_done_wD = 32'h1234;
    @(negedge clk);
    chk("sb_done_stall", 32'(bus.stall), 32'h0);
    chk("sb_done_fwd", bus.new_rD[31:0], 32'h1234);
    tick();

    // WAW and same-cycle set/clear
    clr();
    bus.lu_issue = 1'b1; bus.lu_wR = 5'd3;
    @(negedge clk);
    chk("sb_cleared", bus.busy_vec, 32'h0);
    tick();
    clr();
    bus.id_we = 1'b1; bus.id_wR = 5'd3;
    @(negedge clk);
    chk("waw_busy3", bus.busy_vec, 32'h8);
    chk("waw_stall", 32'(bus.stall), 32'h1);
    tick();
    clr();
    bus.lu_done = 1'b1; bus.lu_done_wR = 5'd3; bus.lu_issue = 1'b1; bus.lu_wR = 5'd3;
    tick();
    clr();
    bus.lu_done = 1'b1; bus.lu_done_wR = 5'd3;
    @(negedge clk);
    chk("set_wins", bus.busy_vec, 32'h8);
    tick();

    // x0 handling
    clr();
    bus.lu_issue = 1'b1; bus.lu_wR = 5'd0;
    tick();
    clr();
    bus.ex_we = 1'b1; bus.ex_wR = 5'd0; bus.ex_wD = 32'h55;
    set_rd(0, 5'd0, 32'h77); bus.id_re = 2'b01;
    @(negedge clk);
    chk("x0_issue", bus.busy_vec, 32'h0);
    chk("x0_read", bus.new_rD[31:0], 32'h77);
    tick();

    // reset mid-operation, late completion is a no-op
    clr();
    bus.lu_issue = 1'b1; bus.lu_wR = 5'd7;
    tick();
    clr();
    rst = 1'b1;
    @(negedge clk);
    chk("busy7", bus.busy_vec, 32'h80);
    tick();
    rst = 1'b0;
    clr();
    bus.lu_done = 1'b1; bus.lu_done_wR = 5'd7;
    @(negedge clk);
    chk("rst_clears_busy", bus.busy_vec, 32'h0);
    tick();
    clr();
    @(negedge clk);
    chk("late_done_noop", bus.busy_vec, 32'h0);
    tick();

    // watchdog: 3 stalls is safe, 4 trips and sticks until reset
    clr();
    bus.ex_we = 1'b1; bus.ex_wR = 5'd7; bus.ex_rdy = 1'b0;
    set_rd(0, 5'd7, 32'h0); bus.id_re = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    clr();
    @(negedge clk);
    chk("wd_3_no_err", 32'(bus.hazard_err), 32'h0);
    tick();
    @(negedge clk);
    chk("wd_3_no_err_after", 32'(bus.hazard_err), 32'h0);
    bus.ex_we = 1'b1; bus.ex_wR = 5'd7; bus.ex_rdy = 1'b0;
    set_rd(0, 5'd7, 32'h0); bus.id_re = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    clr();
    @(negedge clk);
    chk("wd_4_err", 32'(bus.hazard_err), 32'h1);
    tick();
    @(negedge clk);
    chk("wd_err_sticky", 32'(bus.hazard_err), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("wd_err_rst", 32'(bus.hazard_err), 32'h0);
    tick();

    // mixed traffic over a small register window, checked by the model
    for (int n = 0; n < 300; n++) begin
      clr();
      for (int k = 0; k < NRP; k++) set_rd(k, 5'($urandom_range(0, 7)), $urandom());
      bus.id_re    = 2'($urandom());
      bus.id_we    = 1'($urandom());
      bus.id_wR    = 5'($urandom_range(0, 7));
      bus.ex_we    = 1'($urandom());  bus.ex_wR  = 5'($urandom_range(0, 7));
      bus.mem_we   = 1'($urandom());  bus.mem_wR = 5'($urandom_range(0, 7));
      bus.wb_we    = 1'($urandom());  bus.wb_wR  = 5'($urandom_range(0, 7));
      bus.ex_rdy   = ($urandom_range(0, 3) != 0);
      bus.mem_rdy  = ($urandom_range(0, 3) != 0);
      bus.ex_wD    = $urandom(); bus.mem_wD = $urandom(); bus.wb_wD = $urandom();
      bus.lu_issue = ($urandom_range(0, 7) == 0);
      bus.lu_wR    = 5'($urandom_range(0, 7));
      bus.lu_done  = ($urandom_range(0, 3) == 0);
      bus.lu_done_wR = 5'($urandom_range(0, 7));
      bus.lu_done_wD = $urandom();
      tick();
    end
    clr();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
